// File: rtl/cache_port_arbiter.sv
// Round-robin arbiter that funnels NUM_REQ requesters onto one cacheSystem port.
// Runs one transaction at a time through IDLE -> WAIT -> RELEASE and drives only registered outputs.
module cache_port_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32,
  localparam int unsigned ID_W = $clog2(NUM_REQ)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        reqValid,
  input  logic [NUM_REQ-1:0]        reqWrite,
  input  logic [NUM_REQ*ADDR_W-1:0] reqAddr,
  input  logic [NUM_REQ*DATA_W-1:0] reqData,
  output logic [NUM_REQ-1:0]        reqDone,
  output logic [DATA_W-1:0]         respData,
  output logic [ID_W-1:0]           grantId,
  output logic                      busy,
  output logic [15:0]               lastLatency,
  output logic [ADDR_W-1:0]         cacheAddr,
  output logic                      cacheEnable,
  output logic                      cacheWrite,
  output logic [DATA_W-1:0]         cacheDataIn,
  input  logic                      cacheComplete,
  input  logic [DATA_W-1:0]         cacheDataOut
);

  localparam int unsigned LAT_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t             state, stateNext;
  logic [ID_W-1:0]    rrPtr, rrPtrNext;
  logic [LAT_W-1:0]   latCount, latCountNext;
  logic [NUM_REQ-1:0] reqDoneNext;
  logic [DATA_W-1:0]  respDataNext;
  logic [ID_W-1:0]    grantIdNext;
  logic               busyNext;
  logic [LAT_W-1:0]   lastLatencyNext;
  logic [ADDR_W-1:0]  cacheAddrNext;
  logic               cacheEnableNext;
  logic               cacheWriteNext;
  logic [DATA_W-1:0]  cacheDataInNext;

  logic               anyValid;
  logic [ID_W-1:0]    pick;
  logic [ADDR_W-1:0]  addrArr [NUM_REQ];
  logic [DATA_W-1:0]  dataArr [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : gUnpack
    assign addrArr[k] = reqAddr[k*ADDR_W +: ADDR_W];
    assign dataArr[k] = reqData[k*DATA_W +: DATA_W];
  end

  // Modular add for requester indices; NUM_REQ need not be a power of two.
  function automatic logic [ID_W-1:0] wrapAdd(input logic [ID_W-1:0] base,
                                               input logic [ID_W-1:0] inc);
    logic [ID_W:0] sum;
    sum = {1'b0, base} + {1'b0, inc};
    if (sum >= (ID_W+1)'(NUM_REQ)) sum = sum - (ID_W+1)'(NUM_REQ);
    return ID_W'(sum);
  endfunction

  // First valid requester at or after rrPtr.
  always_comb begin
    logic [ID_W-1:0] idx;
    anyValid = 1'b0;
    pick     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = wrapAdd(rrPtr, ID_W'(i));
      if (!anyValid && reqValid[idx]) begin
        anyValid = 1'b1;
        pick     = idx;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      rrPtr       <= '0;
      latCount    <= '0;
      reqDone     <= '0;
      respData    <= '0;
      grantId     <= '0;
      busy        <= 1'b0;
      lastLatency <= '0;
      cacheAddr   <= '0;
      cacheEnable <= 1'b0;
      cacheWrite  <= 1'b0;
      cacheDataIn <= '0;
    end else begin
      state       <= stateNext;
      rrPtr       <= rrPtrNext;
      latCount    <= latCountNext;
      reqDone     <= reqDoneNext;
      respData    <= respDataNext;
      grantId     <= grantIdNext;
      busy        <= busyNext;
      lastLatency <= lastLatencyNext;
      cacheAddr   <= cacheAddrNext;
      cacheEnable <= cacheEnableNext;
      cacheWrite  <= cacheWriteNext;
      cacheDataIn <= cacheDataInNext;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (anyValid) stateNext = WAIT;
      WAIT:    if (cacheComplete) stateNext = RELEASE;
      RELEASE: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Next values of the registered outputs; RELEASE simply lets reqDone fall.
  always_comb begin
    rrPtrNext       = rrPtr;
    latCountNext    = latCount;
    reqDoneNext     = '0;
    respDataNext    = respData;
    grantIdNext     = grantId;
    lastLatencyNext = lastLatency;
    cacheAddrNext   = cacheAddr;
    cacheEnableNext = cacheEnable;
    cacheWriteNext  = cacheWrite;
    cacheDataInNext = cacheDataIn;
    busyNext        = (stateNext != IDLE);
    case (state)
      IDLE: begin
        if (anyValid) begin
          grantIdNext     = pick;
          rrPtrNext       = wrapAdd(pick, ID_W'(1));
          cacheAddrNext   = addrArr[pick];
          cacheWriteNext  = reqWrite[pick];
          cacheDataInNext = dataArr[pick];
          cacheEnableNext = 1'b1;
          latCountNext    = LAT_W'(1);
        end
      end
      WAIT: begin
        if (cacheComplete) begin
          lastLatencyNext = latCount;
          if (!cacheWrite) respDataNext = cacheDataOut;
          cacheEnableNext = 1'b0;
          reqDoneNext     = NUM_REQ'(1) << grantId;
        end else if (latCount != '1) begin
          latCountNext = latCount + LAT_W'(1);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Directed scoreboard bench for cache_port_arbiter with a behavioural cache whose latency can be set per test.
module tb_cache_port_arbiter;

  logic        clock;
  logic        reset;
  logic [3:0]  reqValid;
  logic [3:0]  reqWrite;
  logic [63:0] reqAddr;
  logic [127:0] reqData;
  logic [3:0]  reqDone;
  logic [31:0] respData;
  logic [1:0]  grantId;
  logic        busy;
  logic [15:0] lastLatency;
  logic [15:0] cacheAddr;
  logic        cacheEnable;
  logic        cacheWrite;
  logic [31:0] cacheDataIn;
  logic        cacheComplete;
  logic [31:0] cacheDataOut;

  cache_port_arbiter dut (
    .clock(clock), .reset(reset),
    .reqValid(reqValid), .reqWrite(reqWrite), .reqAddr(reqAddr), .reqData(reqData),
    .reqDone(reqDone), .respData(respData), .grantId(grantId), .busy(busy),
    .lastLatency(lastLatency), .cacheAddr(cacheAddr), .cacheEnable(cacheEnable),
    .cacheWrite(cacheWrite), .cacheDataIn(cacheDataIn),
    .cacheComplete(cacheComplete), .cacheDataOut(cacheDataOut)
  );

  typedef struct {
    logic [1:0]  id;
    logic [15:0] lat;
    logic [31:0] resp;
    logic [15:0] addr;
    logic        wr;
  } exp_t;

  exp_t sbq[$];
  int nVec = 0;
  int nErr = 0;
  int doneCount = 0;
  int cacheLat = 1;
  int enCnt = 0;
  int enTotal = 0;
  int en0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Cache raises complete during its cacheLat-th enable-high cycle.
  always @(negedge clock) begin
    if (cacheEnable === 1'b1) begin
      enCnt++;
      enTotal++;
    end else begin
      enCnt = 0;
    end
    cacheComplete = (cacheEnable === 1'b1) && (enCnt == cacheLat);
    cacheDataOut  = (cacheAddr == 16'h0004) ? 32'hDEADBEEF : {16'hC0DE, cacheAddr};
  end

  // Monitor: every reqDone pulse is matched against the oldest expectation.
  always @(negedge clock) begin
    exp_t e;
    if (reqDone !== 4'b0000 && !reset) begin
      if (sbq.size() == 0) begin
        check("unexpected_done", 32'(reqDone), 32'h0);
      end else begin
        e = sbq.pop_front();
        check("done_grantId", 32'(grantId), 32'(e.id));
        check("done_onehot", 32'(reqDone), 32'(4'(1) << e.id));
        check("done_latency", 32'(lastLatency), 32'(e.lat));
        check("done_respData", respData, e.resp);
        check("done_cacheAddr", 32'(cacheAddr), 32'(e.addr));
        check("done_cacheWrite", 32'(cacheWrite), 32'(e.wr));
        check("done_enable_low", 32'(cacheEnable), 32'h0);
      end
      doneCount++;
    end
  end

  task automatic pushExp(input logic [1:0] id, input logic [15:0] lat, input logic [31:0] resp,
                         input logic [15:0] addr, input logic wr);
    exp_t e;
    e.id = id; e.lat = lat; e.resp = resp; e.addr = addr; e.wr = wr;
    sbq.push_back(e);
  endtask

  task automatic setReq(input int k, input logic wr, input logic [15:0] a, input logic [31:0] d);
    reqWrite[k] = wr;
    reqAddr[k*16 +: 16] = a;
    reqData[k*32 +: 32] = d;
  endtask

  task automatic waitDone(input int target, input int budget);
    int n;
    n = 0;
    while (doneCount < target && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (doneCount < target) check("timeout_done_count", 32'(doneCount), 32'(target));
  endtask

  task automatic doReset();
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; reqValid = '0; reqWrite = '0; reqAddr = '0; reqData = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_enable", 32'(cacheEnable), 32'h0);
    check("rst_write", 32'(cacheWrite), 32'h0);
    check("rst_addr", 32'(cacheAddr), 32'h0);
    check("rst_dataIn", cacheDataIn, 32'h0);
    check("rst_resp", respData, 32'h0);
    check("rst_done", 32'(reqDone), 32'h0);
    check("rst_grant", 32'(grantId), 32'h0);
    check("rst_latency", 32'(lastLatency), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    reset = 1'b0;

    // Single read, 3-cycle cache.
    @(negedge clock);
    setReq(0, 1'b0, 16'h0004, 32'h0);
    cacheLat = 3;
    en0 = enTotal;
    pushExp(2'd0, 16'd3, 32'hDEADBEEF, 16'h0004, 1'b0);
    reqValid = 4'b0001;
    waitDone(1, 50);
    reqValid = 4'b0000;
    repeat (3) @(negedge clock);
    check("t1_enable_cycles", 32'(enTotal - en0), 32'd3);

    // Round-robin from a fresh reset with all requesters held.
    doReset();
    for (int k = 0; k < 4; k++) setReq(k, 1'b0, 16'h0100 + 16'(k), 32'h0);
    cacheLat = 1;
    for (int k = 0; k < 5; k++)
      pushExp(2'(k % 4), 16'd1, 32'hC0DE0100 + 32'(k % 4), 16'h0100 + 16'(k % 4), 1'b0);
    reqValid = 4'b1111;
    waitDone(6, 100);
    reqValid = 4'b0000;
    repeat (3) @(negedge clock);

    // Write from requester 2; respData keeps the last read value.
    setReq(2, 1'b1, 16'h0010, 32'h12345678);
    cacheLat = 2;
    pushExp(2'd2, 16'd2, 32'hC0DE0100, 16'h0010, 1'b1);
    reqValid = 4'b0100;
    @(negedge clock);
    check("t3_enable", 32'(cacheEnable), 32'h1);
    check("t3_write", 32'(cacheWrite), 32'h1);
    check("t3_addr", 32'(cacheAddr), 32'h0010);
    check("t3_dataIn", cacheDataIn, 32'h12345678);
    @(negedge clock);
    check("t3_dataIn_stable", cacheDataIn, 32'h12345678);
    check("t3_write_stable", 32'(cacheWrite), 32'h1);
    waitDone(7, 50);
    reqValid = 4'b0000;
    reqWrite = 4'b0000;
    repeat (3) @(negedge clock);

    // Requester 1 drops reqValid while its transaction is in flight.
    setReq(1, 1'b0, 16'h0101, 32'h0);
    cacheLat = 4;
    pushExp(2'd1, 16'd4, 32'hC0DE0101, 16'h0101, 1'b0);
    reqValid = 4'b0010;
    repeat (2) @(negedge clock);
    reqValid = 4'b0000;
    waitDone(8, 50);
    repeat (10) @(negedge clock);
    check("t4_no_regrant", 32'(doneCount), 32'd8);
    check("t4_busy_idle", 32'(busy), 32'h0);

    // Reset during WAIT aborts silently; search then restarts at requester 0.
    setReq(3, 1'b0, 16'h0103, 32'h0);
    cacheLat = 10;
    reqValid = 4'b1000;
    repeat (3) @(negedge clock);
    check("t5_busy_wait", 32'(busy), 32'h1);
    reset = 1'b1;
    reqValid = 4'b0000;
    @(negedge clock);
    reset = 1'b0;
    check("t5_enable", 32'(cacheEnable), 32'h0);
    check("t5_busy", 32'(busy), 32'h0);
    check("t5_done", 32'(reqDone), 32'h0);
    check("t5_grant", 32'(grantId), 32'h0);
    check("t5_latency", 32'(lastLatency), 32'h0);
    check("t5_resp", respData, 32'h0);
    repeat (3) @(negedge clock);
    check("t5_no_done", 32'(doneCount), 32'd8);
    cacheLat = 1;
    pushExp(2'd1, 16'd1, 32'hC0DE0101, 16'h0101, 1'b0);
    pushExp(2'd3, 16'd1, 32'hC0DE0103, 16'h0103, 1'b0);
    reqValid = 4'b1010;
    waitDone(9, 50);
    reqValid = 4'b1000;
    waitDone(10, 50);
    reqValid = 4'b0000;
    repeat (3) @(negedge clock);

    // Latency counter saturates on a very slow cache.
    setReq(0, 1'b0, 16'h0200, 32'h0);
    cacheLat = 70001;
    pushExp(2'd0, 16'hFFFF, 32'hC0DE0200, 16'h0200, 1'b0);
    reqValid = 4'b0001;
    waitDone(11, 70100);
    reqValid = 4'b0000;
    repeat (3) @(negedge clock);

    check("sb_empty", 32'(sbq.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
